// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: active-low digit
// codes {dp,g,f,e,d,c,b,a} and the scan FSM state type.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    typedef enum logic [0:0] {
        SCAN  = 1'b0,
        GUARD = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_encode.sv
// BCD to active-low seven-segment pattern; codes 10..15 are blank, dp forces bit 7 low.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with guard gaps and frame-aligned
// display updates. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0]   act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*NUM_DIGITS-1:0]   shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]     shd_dp_q, shd_dp_d;
    logic                      pending_q, pending_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     dig_en_q, dig_en_d;

    logic                      advance;
    logic                      boundary;
    logic                      lz_blank;
    logic [3:0]                enc_bcd;
    logic                      enc_dp;
    logic [7:0]                enc_seg;

    // Blanking works on the active registers, so it only changes at frame boundaries.
    always_comb begin
        lz_blank = 1'b0;
`ifdef SEG7_LZB_EN
        lz_blank = (idx_q != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && act_data_q[4*j +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end
`endif
        enc_bcd = lz_blank ? 4'hF : act_data_q[{idx_q, 2'b00} +: 4];
        enc_dp  = act_dp_q[idx_q];
    end

    seg7_encode u_encode (
        .bcd (enc_bcd),
        .dp  (enc_dp),
        .seg (enc_seg)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        shd_data_d = shd_data_q;
        shd_dp_d   = shd_dp_q;
        pending_d  = pending_q;
        advance    = 1'b0;
        boundary   = 1'b0;

        case (state_q)
            SCAN: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = GUARD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GUARD: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase

        if (advance) begin
            state_d = SCAN;
            if (idx_q == IDX_LAST) begin
                idx_d    = '0;
                boundary = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        // Commit looks at the registered pending flag, so a same-cycle accept waits a frame.
        if (boundary && pending_q) begin
            act_data_d = shd_data_q;
            act_dp_d   = shd_dp_q;
            pending_d  = 1'b0;
        end
        if (upd_valid && !pending_q) begin
            shd_data_d = upd_data;
            shd_dp_d   = upd_dp;
            pending_d  = 1'b1;
        end

        if (state_q == SCAN) begin
            seg_d    = enc_seg;
            dig_en_d = ~(NUM_DIGITS'(1) << idx_q);
        end else begin
            seg_d    = SEG_BLANK;
            dig_en_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            cnt_q      <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            pending_q  <= 1'b0;
            seg_q      <= SEG_BLANK;
            dig_en_q   <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    assign upd_ready  = !pending_q;
    assign seg_out    = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4 lit cycles, 2 guard cycles).
module tb_seg7_scan_ctrl;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int BLK = 2;
    localparam int DP  = DIV + BLK;
    localparam int FP  = ND * DP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = 16'h0000;
    logic [3:0]  upd_dp = 4'h0;
    logic        upd_ready;
    logic [7:0]  seg_out;
    logic [3:0]  dig_en;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;

    typedef struct {
        int          acc;
        int          b;
        logic [15:0] w;
        logic [3:0]  dp;
    } upd_t;
    upd_t hist[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    function automatic logic [7:0] code_of(input logic [3:0] v);
        case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_digit(input int d, input logic [15:0] w, input logic [3:0] dp);
        logic [7:0] s;
        logic [15:0] sh;
        s = code_of(4'((w >> (4*d)) & 16'hF));
`ifdef SEG7_LZB_EN
        sh = w >> (4*d);
        if (d > 0 && sh == 16'h0) s = 8'hFF;
`else
        sh = 16'h0;
`endif
        if (dp[d]) s[7] = 1'b0;
        return s;
    endfunction

    // Cycles since reset release: outputs sampled now reflect cycle n-1.
    always @(posedge clk) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    always @(negedge clk) begin : cmp
        logic        exp_rdy;
        logic [7:0]  es;
        logic [3:0]  ed;
        logic [15:0] aw;
        logic [3:0]  adp;
        int          s, p, d, r;
        if (!rst) begin
            hist.delete();
            chk("rst_seg", 16'(seg_out), 16'h00FF);
            chk("rst_dig", 16'(dig_en), 16'h000F);
            chk("rst_fd", 16'(frame_done), 16'h0);
            chk("rst_rdy", 16'(upd_ready), 16'h1);
        end else begin
            exp_rdy = 1'b1;
            foreach (hist[i]) if (hist[i].acc < n && n <= hist[i].b) exp_rdy = 1'b0;
            es = 8'hFF;
            ed = 4'hF;
            if (n > 0) begin
                s = n - 1;
                p = s % FP;
                d = p / DP;
                r = p % DP;
                aw = 16'h0;
                adp = 4'h0;
                foreach (hist[i]) if (hist[i].b < s) begin aw = hist[i].w; adp = hist[i].dp; end
                if (r < DIV) begin
                    es = exp_digit(d, aw, adp);
                    ed = ~(4'b0001 << d);
                end
            end
            chk("seg", 16'(seg_out), 16'(es));
            chk("dig", 16'(dig_en), 16'(ed));
            chk("fd", 16'(frame_done), 16'((n % FP) == FP - 1));
            chk("rdy", 16'(upd_ready), 16'(exp_rdy));
            if (upd_valid && exp_rdy)
                hist.push_back('{acc: n, b: (((n + 1) / FP) + 1) * FP - 1, w: upd_data, dp: upd_dp});
        end
    end

    task automatic wait_n(input int target);
        int guard = 0;
        while (n < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL wait_n: got cycle %0d expected %0d", n, target);
        end
    endtask

    // Offer a word and hold it until accepted; starts just after a rising edge.
    task automatic send(input logic [15:0] w, input logic [3:0] dp);
        logic ok;
        int guard = 0;
        upd_valid = 1'b1;
        upd_data  = w;
        upd_dp    = dp;
        do begin
            @(negedge clk);
            ok = upd_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 300);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
        upd_valid = 1'b0;
        upd_data  = 16'hFFFF;
        upd_dp    = 4'hF;
    endtask

    task automatic drive_at(input int k, input logic [15:0] w, input logic [3:0] dp);
        wait_n(k - 1);
        @(posedge clk);
        #1;
        send(w, dp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset release and plain scan of zeros.
        wait_n(1);  chk("l_dig1", 16'(dig_en), 16'hE); chk("l_seg1", 16'(seg_out), 16'hC0);
        wait_n(5);  chk("l_guard", 16'(dig_en), 16'hF); chk("l_gseg", 16'(seg_out), 16'hFF);
        wait_n(7);  chk("l_dig2", 16'(dig_en), 16'hD);
        wait_n(23); chk("l_fd23", 16'(frame_done), 16'h1);
        wait_n(24); chk("l_fd24", 16'(frame_done), 16'h0);

        // Mid-frame load of 1234 with dp on digit 2.
        drive_at(30, 16'h1234, 4'b0100);
        wait_n(31); chk("l_rdy_low", 16'(upd_ready), 16'h0);
        wait_n(43); chk("l_old_d3", 16'(seg_out), 16'hC0);
        wait_n(48); chk("l_rdy_back", 16'(upd_ready), 16'h1);
        wait_n(49); chk("l_d0", 16'(seg_out), 16'h99);
        wait_n(55); chk("l_d1", 16'(seg_out), 16'hB0);
        wait_n(61); chk("l_d2dp", 16'(seg_out), 16'h24); chk("l_d2en", 16'(dig_en), 16'hB);
        wait_n(67); chk("l_d3", 16'(seg_out), 16'hF9);

        // Second word offered while the first is still pending.
        drive_at(80, 16'h5678, 4'b0000);
        send(16'h9012, 4'b0001);
        wait_n(97);  chk("l_first_d0", 16'(seg_out), 16'h80);
        wait_n(103); chk("l_first_d1", 16'(seg_out), 16'hF8);
        wait_n(119); chk("l_fd119", 16'(frame_done), 16'h1);
        wait_n(121); chk("l_second_d0", 16'(seg_out), 16'h24);

        // Offer exactly in the frame_done cycle.
        drive_at(143, 16'h0987, 4'b0000);
        wait_n(145); chk("l_late_old", 16'(seg_out), 16'h24);
        wait_n(169); chk("l_late_new", 16'(seg_out), 16'hF8);

        // Asynchronous reset during digit 2 with a word pending.
        drive_at(172, 16'h4321, 4'hF);
        wait_n(180);
        @(posedge clk);
        #1;
        chk("l_pre_rst_seg", 16'(seg_out), 16'h90);
        chk("l_pre_rst_dig", 16'(dig_en), 16'hB);
        rst = 1'b0;
        #1;
        chk("l_arst_seg", 16'(seg_out), 16'hFF);
        chk("l_arst_dig", 16'(dig_en), 16'hF);
        chk("l_arst_rdy", 16'(upd_ready), 16'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_n(1);  chk("l_rs_dig", 16'(dig_en), 16'hE); chk("l_rs_seg", 16'(seg_out), 16'hC0);
        wait_n(25); chk("l_lost", 16'(seg_out), 16'hC0);

        // Leading-zero handling.
        drive_at(30, 16'h0070, 4'b0000);
        wait_n(49); chk("l_z_d0", 16'(seg_out), 16'hC0);
        wait_n(55); chk("l_z_d1", 16'(seg_out), 16'hF8);
`ifdef SEG7_LZB_EN
        wait_n(61); chk("l_z_d2", 16'(seg_out), 16'hFF);
        wait_n(67); chk("l_z_d3", 16'(seg_out), 16'hFF);
`else
        wait_n(61); chk("l_z_d2", 16'(seg_out), 16'hC0);
        wait_n(67); chk("l_z_d3", 16'(seg_out), 16'hC0);
`endif
        drive_at(70, 16'h0000, 4'b0000);
        wait_n(97); chk("l_zz_d0", 16'(seg_out), 16'hC0);
`ifdef SEG7_LZB_EN
        wait_n(103); chk("l_zz_d1", 16'(seg_out), 16'hFF);
`else
        wait_n(103); chk("l_zz_d1", 16'(seg_out), 16'hC0);
`endif
        wait_n(130);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
